// File: rtl/phase_advance_gen_pkg.sv
// Phase codes shared by the advance generator and the downstream phase
// state machine.
package phase_advance_gen_pkg;

   localparam int PH_W = 3;

   typedef logic [PH_W-1:0] phase_t;

   localparam phase_t PH_INIT = 3'd0;
   localparam phase_t PH_A    = 3'd1;
   localparam phase_t PH_B    = 3'd2;
   localparam phase_t PH_C    = 3'd3;

   function automatic logic is_phase(input phase_t p);
      return (p == PH_A) || (p == PH_B) || (p == PH_C);
   endfunction

endpackage

// File: rtl/phase_advance_gen_counter.sv
// Per-phase unit counter: latches the active phase length on entry and
// counts completed units against it, saturating at all-ones.
module phase_unit_counter
   import phase_advance_gen_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   input  logic [PH_W-1:0]  phase,
   input  logic [CNT_W-1:0] len_a,
   input  logic [CNT_W-1:0] len_b,
   input  logic [CNT_W-1:0] len_c,
   output logic [CNT_W-1:0] unit_cnt,
   output logic [CNT_W-1:0] target,
   output logic             reach
);

   logic [CNT_W-1:0] len_sel;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      len_sel = '0;
      unique case (1'b1)
         (phase == PH_A): len_sel = len_a;
         (phase == PH_B): len_sel = len_b;
         (phase == PH_C): len_sel = len_c;
         default:         len_sel = '0;
      endcase
   end

   assign cnt_nxt = (&unit_cnt) ? unit_cnt : unit_cnt + CNT_W'(1);
   assign reach   = (cnt_nxt >= target);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unit_cnt <= '0;
         target   <= '0;
      end else if (load) begin
         unit_cnt <= '0;
         target   <= len_sel;
      end else if (inc) begin
         unit_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/phase_advance_gen.sv
// Drives single-cycle advance pulses into the phase state machine once
// each phase has completed its programmed number of work units.
module phase_advance_gen
   import phase_advance_gen_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             loop_en,
   input  logic [PH_W-1:0]  current_state,
   input  logic [CNT_W-1:0] len_a,
   input  logic [CNT_W-1:0] len_b,
   input  logic [CNT_W-1:0] len_c,
   input  logic             done_in,
   output logic             state_rst,
   output logic             busy,
   output logic [CNT_W-1:0] unit_cnt,
   output logic             frame_done,
   output logic             seq_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   logic [1:0]       st;
   logic [1:0]       st_n;
   logic [PH_W-1:0]  cap;
   logic [PH_W-1:0]  cap_n;
   logic [WC_W-1:0]  wcnt;
   logic [WC_W-1:0]  wcnt_n;
   logic             pulse;
   logic             fdone;
   logic             err;
   logic             load;
   logic             run_inc;
   logic             reach;
   logic [CNT_W-1:0] target;

   assign run_inc = (st == ST_RUN) && done_in
                  && is_phase(current_state)
                  && (target != '0);

   phase_unit_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .inc      (run_inc),
      .phase    (current_state),
      .len_a    (len_a),
      .len_b    (len_b),
      .len_c    (len_c),
      .unit_cnt (unit_cnt),
      .target   (target),
      .reach    (reach)
   );

   always_comb begin
      st_n   = st;
      cap_n  = cap;
      wcnt_n = wcnt;
      pulse  = 1'b0;
      fdone  = 1'b0;
      err    = seq_err;
      load   = 1'b0;
      unique case (st)
         ST_IDLE: begin
            if (done_in) err = 1'b1;
            if (start) begin
               if (current_state == PH_INIT) begin
                  pulse  = 1'b1;
                  cap_n  = current_state;
                  wcnt_n = '0;
                  st_n   = ST_WAIT;
               end else if (is_phase(current_state)) begin
                  load = 1'b1;
                  st_n = ST_RUN;
               end else begin
                  err = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (done_in) err = 1'b1;
            if (current_state != cap) begin
               // After C the machine wraps to A; only re-run it when looping.
               if (cap == PH_C &&
                   !(current_state == PH_A && loop_en)) begin
                  st_n = ST_IDLE;
               end else begin
                  load = 1'b1;
                  st_n = ST_RUN;
               end
            end else if (wcnt == WC_W'(WAIT_MAX)) begin
               err  = 1'b1;
               st_n = ST_IDLE;
            end else begin
               wcnt_n = wcnt + WC_W'(1);
            end
         end
         ST_RUN: begin
            if (!is_phase(current_state)) begin
               err  = 1'b1;
               st_n = ST_IDLE;
            end else if (target == '0 || (done_in && reach)) begin
               pulse  = 1'b1;
               fdone  = (current_state == PH_C);
               cap_n  = current_state;
               wcnt_n = '0;
               st_n   = ST_WAIT;
            end
         end
         default: st_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= ST_IDLE;
         cap        <= PH_INIT;
         wcnt       <= '0;
         state_rst  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         st         <= st_n;
         cap        <= cap_n;
         wcnt       <= wcnt_n;
         state_rst  <= pulse & ~state_rst;
         busy       <= (st_n != ST_IDLE);
         frame_done <= fdone & ~state_rst;
         seq_err    <= err;
      end
   end

endmodule

// File: doc/phase_advance_gen.md
PHASE_ADVANCE_GEN -- requirements
Module: phase_advance_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-phase unit counters.
REQ-002 SHALL have parameter WAIT_MAX, default 4, max cycles to wait for a state change after an advance pulse.
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin sequencing.
REQ-006 loop_en  input  1  continue into phase A after phase C completes.
REQ-007 current_state  input  3  phase code from the downstream phase state machine (INIT=0, A=1, B=2, C=3).
REQ-008 len_a, len_b, len_c  input  CNT_W each  units per phase, sampled on phase entry.
REQ-009 done_in  input  1  one pulse per completed work unit.
REQ-010 state_rst  output  1  single-cycle advance pulse to the phase state machine.
REQ-011 busy  output  1  high in any non-IDLE state.
REQ-012 unit_cnt  output  CNT_W  units completed in the current phase.
REQ-013 frame_done  output  1  single-cycle pulse when phase C completes.
REQ-014 seq_err  output  1  sticky error flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RUN; all outputs registered.
REQ-016 IDLE: start with current_state=INIT -> state_rst=1 next cycle, enter WAIT; start with current_state in {A,B,C} -> enter RUN directly, no pulse.
REQ-017 WAIT: capture current_state at pulse; first cycle current_state differs -> next cycle enter RUN, unit_cnt=0, target loaded from len_x of new phase.
REQ-018 WAIT: no change within WAIT_MAX cycles after the pulse -> seq_err=1, enter IDLE.
REQ-019 RUN: each done_in increments unit_cnt by 1; done_in bringing unit_cnt to target -> state_rst=1 next cycle (one-cycle latency), enter WAIT.
REQ-020 RUN with target=0 -> state_rst=1 the cycle after RUN entry, no done_in needed.
REQ-021 Phase C completion -> frame_done=1 in same cycle as state_rst; after WAIT sees A: loop_en=1 -> RUN in A, loop_en=0 -> IDLE.
REQ-022 done_in in IDLE or WAIT -> dropped, seq_err=1.
REQ-023 current_state in 4..7 while in RUN or at IDLE start -> seq_err=1, enter IDLE, no pulse.
REQ-024 start while busy -> ignored, no error.
REQ-025 unit_cnt SHALL saturate at 2^CNT_W-1; no wrap.
REQ-026 state_rst never high on two consecutive cycles.
REQ-027 seq_err cleared only by rst.

Reset
REQ-028 rst assertion SHALL asynchronously force IDLE, state_rst=0, busy=0, unit_cnt=0, frame_done=0, seq_err=0, target=0.
REQ-029 rst mid-phase SHALL discard progress; first cycle after release behaves as IDLE.

Structure
REQ-030 Phase codes INIT/A/B/C and their 3-bit width SHALL live in a shared package used by this block and the phase state machine.
REQ-031 Local FSM codes SHALL remain inside this module.
REQ-032 Per-phase limit mux plus unit counter SHALL be one sub-module, phase_unit_counter.

Verification
REQ-033 Paired with phase state machine, len_a=2,len_b=3,len_c=1, loop_en=0, start -> states 0,1,2,3,1; state_rst exactly 4 pulses; frame_done once; IDLE in A.
REQ-034 len_b=0 -> B passes with state_rst the cycle after RUN entry in B, unit_cnt stays 0.
REQ-035 current_state held at 0 (no phase machine), start -> one state_rst pulse, seq_err=1 after 4 cycles, IDLE.
REQ-036 done_in during WAIT -> seq_err=1, unit_cnt in next phase starts 0.
REQ-037 rst at unit_cnt=5 of len_a=8 -> all outputs 0 asynchronously, next start from INIT restarts cleanly.
REQ-038 loop_en=1, len_a=len_b=len_c=1, 3 frames -> frame_done 3 pulses, state sequence repeats A,B,C.
